// File: rtl/serial_tx.sv
// Framed asynchronous serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                out_q, out_d;
  logic                done_q, done_d;
  logic                baud_last;
`ifdef SERIAL_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      out_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    out_d    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d  = tx_data;
          baud_d   = '0;
          idx_d    = '0;
          state_d  = START;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_ONE;
          end
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        idx_d   = '0;
      end
    endcase

    // Line level is derived from the upcoming state so the registered output
    // lines up with the state it belongs to, without a combinational tail.
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  out_d = parity_d;
`endif
      default: out_d = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_out   = out_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: reset, framing, back-to-back, busy-ignore, mid-frame reset
// and, with SERIAL_TX_PARITY_EN defined, the parity bit.
module tb_serial_tx;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level i cycles after the accepting edge (i = 0 is the first start-bit clock).
  function automatic logic exp_line(input logic [7:0] d, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    #3;
    checks++; if (tx_out !== 1'b1)   begin errors++; $display("FAIL reset_out: got %b exp 1", tx_out); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b exp 0", tx_busy); end
    checks++; if (tx_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b exp 0", tx_done); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_no_accept: busy got %b exp 0", tx_busy); end
    checks++; if (tx_out !== 1'b1)   begin errors++; $display("FAIL reset_hold_out: got %b exp 1", tx_out); end
    #6 reset = 1'b0;
    #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b exp 1", tx_ready); end
    step();
    tx_valid = 1'b0;
    checks++; if (tx_busy !== 1'b1)  begin errors++; $display("FAIL first_accept_busy: got %b exp 1", tx_busy); end
    checks++; if (tx_out !== 1'b0)   begin errors++; $display("FAIL first_accept_start: got %b exp 0", tx_out); end
    for (int i = 0; i < FRAME; i++) step();
    checks++; if (tx_done !== 1'b1)  begin errors++; $display("FAIL first_frame_done: got %b exp 1", tx_done); end
    step();
  endtask

  task automatic test_basic_frame();
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_before: got %b exp 1", tx_ready); end
    send(8'hA5);
    tx_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (tx_out !== exp_line(8'hA5, i)) begin
        errors++; $display("FAIL basic_line[%0d]: got %b exp %b", i, tx_out, exp_line(8'hA5, i));
      end
      checks++;
      if (tx_busy !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b0) begin
        errors++; $display("FAIL basic_flags[%0d]: busy/done/ready got %b%b%b exp 100", i, tx_busy, tx_done, tx_ready);
      end
      step();
    end
    checks++; if (tx_done !== 1'b1)  begin errors++; $display("FAIL basic_done: got %b exp 1", tx_done); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b exp 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL basic_busy_after: got %b exp 0", tx_busy); end
    checks++; if (tx_out !== 1'b1)   begin errors++; $display("FAIL basic_idle_line: got %b exp 1", tx_out); end
    step();
    checks++; if (tx_done !== 1'b0)  begin errors++; $display("FAIL basic_done_once: got %b exp 0", tx_done); end
  endtask

  task automatic test_back_to_back();
    logic e;
    send(8'h00);
    tx_data = 8'hFF;
    for (int i = 0; i <= 2 * FRAME + 1; i++) begin
      if (i < FRAME) e = exp_line(8'h00, i);
      else if (i == FRAME || i == 2 * FRAME + 1) e = 1'b1;
      else e = exp_line(8'hFF, i - FRAME - 1);
      checks++;
      if (tx_out !== e) begin
        errors++; $display("FAIL b2b_line[%0d]: got %b exp %b", i, tx_out, e);
      end
      checks++;
      if (tx_busy !== !(i == FRAME || i == 2 * FRAME + 1)) begin
        errors++; $display("FAIL b2b_busy[%0d]: got %b exp %b", i, tx_busy, !(i == FRAME || i == 2 * FRAME + 1));
      end
      checks++;
      if (tx_done !== (i == FRAME || i == 2 * FRAME + 1)) begin
        errors++; $display("FAIL b2b_done[%0d]: got %b exp %b", i, tx_done, (i == FRAME || i == 2 * FRAME + 1));
      end
      if (i == FRAME + 1) tx_valid = 1'b0;
      step();
    end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL b2b_no_third: busy got %b exp 0", tx_busy); end
    checks++; if (tx_done !== 1'b0)  begin errors++; $display("FAIL b2b_done_clear: got %b exp 0", tx_done); end
  endtask

  task automatic test_ignore_while_busy();
    send(8'h3C);
    tx_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (tx_out !== exp_line(8'h3C, i)) begin
        errors++; $display("FAIL ignore_line[%0d]: got %b exp %b", i, tx_out, exp_line(8'h3C, i));
      end
      checks++;
      if (tx_ready !== 1'b0) begin
        errors++; $display("FAIL ignore_ready[%0d]: got %b exp 0", i, tx_ready);
      end
      if (i == 12) begin tx_data = 8'hC3; tx_valid = 1'b1; end
      if (i == 16) tx_valid = 1'b0;
      step();
    end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b exp 1", tx_done); end
    step();
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL ignore_no_extra: busy got %b exp 0", tx_busy); end
    checks++; if (tx_out !== 1'b1)  begin errors++; $display("FAIL ignore_idle_line: got %b exp 1", tx_out); end
  endtask

  task automatic test_reset_mid_frame();
    send(8'h3C);
    tx_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b exp 1", tx_busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tx_out !== 1'b1)   begin errors++; $display("FAIL midrst_out: got %b exp 1", tx_out); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b exp 0", tx_busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b exp 1", tx_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done[%0d]: got %b exp 0", i, tx_done); end
    end
    #2 reset = 1'b0;
    step();
    checks++; if (tx_done !== 1'b0)  begin errors++; $display("FAIL midrst_release_done: got %b exp 0", tx_done); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b exp 1", tx_ready); end
    send(8'h81);
    tx_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (tx_out !== exp_line(8'h81, i)) begin
        errors++; $display("FAIL midrst_81_line[%0d]: got %b exp %b", i, tx_out, exp_line(8'h81, i));
      end
      step();
    end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL midrst_81_done: got %b exp 1", tx_done); end
    step();
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       pbit  [2];
    words[0] = 8'h07; pbit[0] = 1'b1;
    words[1] = 8'h03; pbit[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      send(words[w]);
      tx_valid = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        checks++;
        if (tx_out !== exp_line(words[w], i)) begin
          errors++; $display("FAIL parity_line[%0d][%0d]: got %b exp %b", w, i, tx_out, exp_line(words[w], i));
        end
        if (i == 9 * CPB) begin
          checks++;
          if (tx_out !== pbit[w]) begin
            errors++; $display("FAIL parity_bit[%0d]: got %b exp %b", w, tx_out, pbit[w]);
          end
        end
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL parity_busy[%0d][%0d]: got %b exp 1", w, i, tx_busy); end
        step();
      end
      checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL parity_done[%0d]: got %b exp 1", w, tx_done); end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_frame();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
